// File: rtl/v_pkg.sv
// Shared types for the v core.
// pc_t / insn_t / insn_queue_entry_t describe a fetched instruction at the
// default PC width. V_INSN_QUEUE_N_DEFAULT is the default instruction queue
// depth.
package v_pkg;

  localparam int V_PC_W                 = 32;
  localparam int V_INSN_QUEUE_N_DEFAULT = 4;

  typedef logic [V_PC_W-1:0] pc_t;
  typedef logic [31:0]       insn_t;

  typedef struct packed {
    pc_t   pc;
    insn_t insn;
  } insn_queue_entry_t;

endpackage

// File: rtl/v_insn_queue_ram.sv
// Storage array for v_insn_queue.
// N entries of W bits, one synchronous write port and one asynchronous read
// port. Contents are not reset.
// Ports: clk, we/waddr/wdata (write port), raddr/rdata (read port).
module v_insn_queue_ram #(
  parameter int N  = 4,
  parameter int W  = 64,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/v_insn_queue.sv
// Decoupling instruction queue between fetch and decode.
// Buffers up to N {pc, insn} pairs in order, with valid/ready handshakes on
// both sides, a synchronous flush for redirects, and an occupancy output so
// fetch can throttle before the queue fills.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   push_vld/push_rdy/push_pc/push_insn  fetch side
//   pop_vld/pop_rdy/pop_pc/pop_insn      decode side
//   flush                         discard all entries this cycle
//   occ                           current entry count, 0..N
// Optional feature: define V_INSN_QUEUE_BYPASS_EN to let a push into an
// empty queue appear on the pop side in the same cycle.
module v_insn_queue
  import v_pkg::*;
#(
  parameter int N    = V_INSN_QUEUE_N_DEFAULT,
  parameter int PC_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_vld,
  input  logic [PC_W-1:0]        push_pc,
  input  logic [31:0]            push_insn,
  output logic                   push_rdy,
  output logic                   pop_vld,
  output logic [PC_W-1:0]        pop_pc,
  output logic [31:0]            pop_insn,
  input  logic                   pop_rdy,
  input  logic                   flush,
  output logic [$clog2(N+1)-1:0] occ
);

  localparam int AW = $clog2(N);
  localparam int PW = AW + 1;
  localparam int OW = $clog2(N + 1);
  localparam int EW = PC_W + 32;

  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [OW-1:0] OCC_ONE = OW'(1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          byp;
  logic          push_fire;
  logic          pop_fire;
  logic          wr_en;
  logic          rd_inc;
  logic [EW-1:0] rd_entry;
  insn_t         head_insn;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign push_rdy = !full && !flush && !rst;

`ifdef V_INSN_QUEUE_BYPASS_EN
  // An offered push into an empty queue is presented straight to decode.
  assign byp = empty && push_vld && !flush && !rst;
  assign pop_vld  = (!empty || byp) && !flush && !rst;
  assign pop_pc   = byp ? push_pc   : rd_entry[EW-1:32];
  assign head_insn = byp ? push_insn : rd_entry[31:0];
`else
  assign byp = 1'b0;
  assign pop_vld  = !empty && !flush && !rst;
  assign pop_pc   = rd_entry[EW-1:32];
  assign head_insn = rd_entry[31:0];
`endif
  assign pop_insn = head_insn;

  assign push_fire = push_vld && push_rdy;
  assign pop_fire  = pop_vld && pop_rdy;

  // A bypassed entry that decode takes immediately is never stored, and a
  // bypass pop does not consume a stored entry.
  assign wr_en  = push_fire && !(byp && pop_rdy);
  assign rd_inc = pop_fire && !byp;

  v_insn_queue_ram #(
    .N  (N),
    .W  (EW),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({push_pc, push_insn}),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      occ    <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_inc) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, rd_inc})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: doc/v_insn_queue.md
# v_insn_queue

Decoupling instruction queue between the fetch stage and decode inside `v`. It accepts fetched {pc, insn} pairs from fetch through a valid/ready handshake, buffers up to N entries in order, and presents them to decode. A synchronous flush discards all contents on redirect. It exposes occupancy so fetch can throttle ahead of full.

## Interface
Parameters:
- `N`, 4: queue depth in entries; power of two, ≥ 2.
- `PC_W`, 32: program-counter width.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `push_vld`  in  1  fetch presents an entry.
- `push_pc`  in  PC_W  entry PC.
- `push_insn`  in  32  entry instruction word.
- `push_rdy`  out  1  queue can accept; a push occurs when `push_vld & push_rdy`.
- `pop_vld`  out  1  head entry valid toward decode.
- `pop_pc`  out  PC_W  head PC.
- `pop_insn`  out  32  head instruction.
- `pop_rdy`  in  1  decode accepts; a pop occurs when `pop_vld & pop_rdy`.
- `flush`  in  1  discard all entries this cycle.
- `occ`  out  $clog2(N+1)  current entry count, 0..N.

## Operation
- Storage: N-entry array; `wr_ptr` and `rd_ptr` are $clog2(N)+1 bits (wrap bit + index).
- Empty: `wr_ptr == rd_ptr`. Full: index bits equal, wrap bits differ.
- `push_rdy = !full & !flush & !rst`. It does not depend on `pop_rdy`, so no push-through when full.
- `pop_vld = !empty & !flush & !rst`. `pop_pc`/`pop_insn` show the head entry; they are don't-care when `pop_vld`=0.
- Push writes `array[wr_ptr]` and increments `wr_ptr`. Pop increments `rd_ptr`. Both may occur in the same cycle, in which case `occ` is unchanged.
- Pointer arithmetic is modulo 2N, so wrap-around is natural. Index = low $clog2(N) bits.
- `occ = wr_ptr - rd_ptr` (mod 2N), registered state, never exceeds N.
- Flush: next cycle `rd_ptr <= wr_ptr`, `occ` = 0. A push offered in the flush cycle is dropped; no pop occurs in the flush cycle.
- Priority: `rst` > `flush` > push/pop.

## Timing
- Reset values: pointers 0, `occ`=0, `pop_vld`=0, `push_rdy`=0 while `rst`=1. `push_rdy`=1 in the first cycle after `rst` deasserts.
- Array contents are not reset.
- Latency without bypass: an entry pushed at cycle t is poppable at cycle t+1.
- Sustained throughput: 1 push and 1 pop per cycle with no bubbles when 0 < occ < N.
- When full, `push_rdy` drops in the cycle after the Nth push and rises in the cycle after the first pop.
- Reset or flush mid-operation: all entries are lost, with no partial state.

## Configuration
- `V_INSN_QUEUE_BYPASS_EN` defined: when empty and `push_vld` and not `flush`:
  - `pop_vld`=1 combinationally, with `pop_pc`/`pop_insn` taken from the push inputs.
  - If `pop_rdy`=1, the entry is consumed and not written; `occ` stays 0.
  - If `pop_rdy`=0, the entry is written normally.
  - Zero-cycle latency when empty.
- Undefined: no combinational path from push inputs to pop outputs; minimum latency is 1 cycle.

## Structure
- Shared package `v_pkg`:
  - `pc_t` (logic [PC_W-1:0]) and `insn_t` (logic [31:0]).
  - `insn_queue_entry_t` struct {pc_t pc; insn_t insn;}.
  - `V_INSN_QUEUE_N_DEFAULT` = 4.
- One sub-module, `v_insn_queue_ram`: N × entry storage with 1 write port and 1 asynchronous read port, no reset. Pointer/control logic stays in `v_insn_queue`.

## Test plan
- Reset then idle: `rst` held 3 cycles → `occ`=0, `pop_vld`=0 throughout; `push_rdy`=1 on the first cycle after release.
- Fill/drain, N=4: push pc 0x100,0x104,0x108,0x10C with `pop_rdy`=0 → `occ`=4, `push_rdy`=0. Then `pop_rdy`=1 → pops in the same order, one per cycle, and `occ` goes 3,2,1,0.
- Streaming wrap: push and pop simultaneously every cycle for 20 cycles with occ held at 2 → `occ` constant 2, output PCs strictly in order, pointers wrap without loss.
- Flush while pushing: `occ`=3, assert `flush` with `push_vld`=1 (pc 0x200) → that cycle `pop_vld`=0 and `push_rdy`=0; next cycle `occ`=0 and 0x200 is never popped.
- Full boundary: `occ`=4, pop and offer a push in the same cycle → push is rejected (`push_rdy`=0), `occ`=3 next cycle, and the push is accepted the following cycle.
- Bypass (macro on): empty queue, push 0x300 with `pop_rdy`=1 → `pop_vld`=1 with `pop_pc`=0x300 in the same cycle, `occ` stays 0. Macro off → same stimulus pops 0x300 one cycle later.
